// File: rtl/ksa32_issue_stage_pkg.sv
// Shared types for the KSA32 issue stage: word width, FSM states, result record.
package ksa_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic {
    IDLE,
    SETTLE
  } ksa_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] sum;
    logic              cout;
    logic              ovf;
  } ksa_result_t;

endpackage

// File: rtl/ksa32_issue_stage_if.sv
// Operand and result valid/ready streams of the KSA32 issue stage.
interface ksa32_issue_stage_if;
  import ksa_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_a;
  logic [WORD_W-1:0] in_b;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_sum;
  logic              out_cout;
  logic              out_ovf;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

endinterface

// File: rtl/ksa32_issue_stage_fifo.sv
// Small synchronous result FIFO with occupancy output; head reads as zero when empty.
module ksa_result_fifo
  import ksa_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  ksa_result_t       data_i,
  input  logic              pop_i,
  output ksa_result_t       head_o,
  output logic [CNT_W-1:0]  count_o
);

  ksa_result_t       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok, pop_ok, full, empty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign pop_ok  = pop_i && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push_i && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= data_i;
  end

  assign head_o  = empty ? '0 : mem[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ksa32_issue_stage.sv
// Issue/capture wrapper that runs the external KSA32 adder as a multicycle path.
// Define KSA_ISSUE_STATS_EN to add op_count/ovf_count statistics outputs.
module ksa32_issue_stage
  import ksa_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned OBUF_DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  ksa32_issue_stage_if.slave bus,
  output logic [WORD_W-1:0] adder_a,
  output logic [WORD_W-1:0] adder_b,
  input  logic [WORD_W-1:0] adder_sum,
  input  logic              adder_cout,
  input  logic              adder_ovf,
  output logic              busy
`ifdef KSA_ISSUE_STATS_EN
  ,
  output logic [31:0]       op_count,
  output logic [15:0]       ovf_count
`endif
);

  localparam int unsigned CNT_W = $clog2(OBUF_DEPTH + 1);

  ksa_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] a_q, a_d;
  logic [WORD_W-1:0] b_q, b_d;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  fifo_count;
  ksa_result_t       push_data;
  ksa_result_t       head;

  // Keeping a slot free while an op is in flight means a capture never finds the FIFO full.
  assign bus.in_ready = (state_q == IDLE) && (fifo_count < CNT_W'(OBUF_DEPTH));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          state_d = SETTLE;
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          cnt_d   = 4'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign push_data = '{sum: adder_sum, cout: adder_cout, ovf: adder_ovf};
  assign pop       = bus.out_valid && bus.out_ready;

  ksa_result_fifo #(
    .DEPTH (OBUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (fifo_count)
  );

  assign bus.out_valid = (fifo_count != '0);
  assign bus.out_sum   = head.sum;
  assign bus.out_cout  = head.cout;
  assign bus.out_ovf   = head.ovf;

  assign adder_a = a_q;
  assign adder_b = b_q;
  assign busy    = (state_q != IDLE);

`ifdef KSA_ISSUE_STATS_EN
  logic [31:0] op_count_q;
  logic [15:0] ovf_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count_q  <= '0;
      ovf_count_q <= '0;
    end else if (push) begin
      op_count_q <= op_count_q + 1'b1;
      if (adder_ovf && (ovf_count_q != '1)) ovf_count_q <= ovf_count_q + 1'b1;
    end
  end

  assign op_count  = op_count_q;
  assign ovf_count = ovf_count_q;
`endif

endmodule

// File: tb/tb_ksa32_issue_stage.sv
// Directed bench for ksa32_issue_stage with a behavioural stand-in for the KSA32 adder.
module tb_ksa32_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adder_a, adder_b, adder_sum;
  logic        adder_cout, adder_ovf, busy;
`ifdef KSA_ISSUE_STATS_EN
  logic [31:0] op_count;
  logic [15:0] ovf_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  ksa32_issue_stage_if bus();

  ksa32_issue_stage #(
    .SETTLE_CYCLES (2),
    .OBUF_DEPTH    (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .adder_a    (adder_a),
    .adder_b    (adder_b),
    .adder_sum  (adder_sum),
    .adder_cout (adder_cout),
    .adder_ovf  (adder_ovf),
    .busy       (busy)
`ifdef KSA_ISSUE_STATS_EN
    ,
    .op_count   (op_count),
    .ovf_count  (ovf_count)
`endif
  );

  // Stand-in for KSA32_top: 33-bit add, signed overflow from operand/result signs.
  assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b};
  assign adder_ovf = (adder_a[31] == adder_b[31]) && (adder_sum[31] != adder_a[31]);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int  n = 0;
    logic timed_out;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    timed_out = (n >= 100);
    check("send_timeout", 64'(timed_out), 64'd0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int n, output logic [31:0] s,
                             output logic c, output logic o);
    logic timed_out;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 50);
    timed_out = !bus.out_valid;
    check("result_timeout", 64'(timed_out), 64'd0);
    s = bus.out_sum;
    c = bus.out_cout;
    o = bus.out_ovf;
  endtask

  task automatic op_expect(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] es, input logic ec, input logic eo);
    int n;
    logic [31:0] s;
    logic c, o;
    send(a, b);
    wait_result(n, s, c, o);
    check({tag, "_sum"},  64'(s), 64'(es));
    check({tag, "_cout"}, 64'(c), 64'(ec));
    check({tag, "_ovf"},  64'(o), 64'(eo));
  endtask

  initial begin
    int n;
    logic [31:0] s;
    logic c, o;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_sum",   64'(bus.out_sum),   64'd0);
    check("rst_busy",      64'(busy),          64'd0);
    check("rst_adder_a",   64'(adder_a),       64'd0);

    // 1. single op and latency
    send(32'h1, 32'h2);
    check("t1_busy", 64'(busy), 64'd1);
    wait_result(n, s, c, o);
    check("t1_latency", 64'(n), 64'd3);
    check("t1_sum",  64'(s), 64'h3);
    check("t1_cout", 64'(c), 64'd0);
    check("t1_ovf",  64'(o), 64'd0);
    @(negedge clk);
    check("t1_popped",    64'(bus.out_valid), 64'd0);
    check("t1_empty_sum", 64'(bus.out_sum),   64'd0);
    check("t1_a_held",    64'(adder_a),       64'h1);
    check("t1_b_held",    64'(adder_b),       64'h2);

    // 2. wrap and overflow
    op_expect("t2_wrap", 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0);
    op_expect("t2_ovf",  32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1);

    // 3. backpressure with three ops
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(32'd10, 32'd20);
    send(32'd3, 32'd4);
    repeat (3) @(negedge clk);
    check("t3_full_ready", 64'(bus.in_ready),  64'd0);
    check("t3_full_valid", 64'(bus.out_valid), 64'd1);
    check("t3_head0",      64'(bus.out_sum),   64'd30);
    bus.in_valid = 1'b1;
    bus.in_a     = 32'd100;
    bus.in_b     = 32'd200;
    repeat (2) @(negedge clk);
    check("t3_ignored_busy", 64'(busy),        64'd0);
    check("t3_head_stable",  64'(bus.out_sum), 64'd30);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t3_head1",       64'(bus.out_sum),  64'd7);
    check("t3_ready_again", 64'(bus.in_ready), 64'd1);
    check("t3_not_yet",     64'(busy),         64'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("t3_accepted",    64'(busy),         64'd1);
    repeat (2) @(negedge clk);
    check("t3_full2_ready", 64'(bus.in_ready), 64'd0);
    check("t3_head1_hold",  64'(bus.out_sum),  64'd7);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t3_head2",  64'(bus.out_sum),   64'd300);
    @(negedge clk);
    check("t3_drained", 64'(bus.out_valid), 64'd0);

    // 4. push and pop on the same edge
    bus.out_ready = 1'b0;
    send(32'd5, 32'd6);
    wait_result(n, s, c, o);
    check("t4_head_a", 64'(s), 64'd11);
    send(32'd7, 32'd8);
    @(negedge clk);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t4_valid", 64'(bus.out_valid),       64'd1);
    check("t4_head_b", 64'(bus.out_sum),        64'd15);
    check("t4_count", 64'(dut.u_fifo.count_o),  64'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t4_drained", 64'(bus.out_valid), 64'd0);

    // 5. reset while settling
    send(32'h1234, 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_in_ready",  64'(bus.in_ready),  64'd1);
    check("t5_out_valid", 64'(bus.out_valid), 64'd0);
    check("t5_adder_a",   64'(adder_a),       64'd0);
    check("t5_busy",      64'(busy),          64'd0);
    repeat (6) @(negedge clk);
    check("t5_no_stale",  64'(bus.out_valid), 64'd0);

    // 6. four ops, two overflowing
    op_expect("t6_op0", 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b1);
    op_expect("t6_op1", 32'h8000_0000, 32'h8000_0000, 32'h0,         1'b1, 1'b1);
    op_expect("t6_op2", 32'h1,         32'h1,         32'h2,         1'b0, 1'b0);
    op_expect("t6_op3", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0);
`ifdef KSA_ISSUE_STATS_EN
    check("t6_op_count",  64'(op_count),  64'd4);
    check("t6_ovf_count", 64'(ovf_count), 64'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
